// File: rtl/id_ex_issue_pkg.sv
// rtl/id_ex_issue_pkg.sv - opcode, funct and ALU class constants for the ID/EX issue stage
package id_ex_issue_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JALR  = 6'b001001;

    localparam logic [3:0] ALU_R    = 4'b0000;
    localparam logic [3:0] ALU_MEM  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_ADDI = 4'b1001;
    localparam logic [3:0] ALU_ANDI = 4'b1010;
    localparam logic [3:0] ALU_ORI  = 4'b1011;
    localparam logic [3:0] ALU_XORI = 4'b1100;
    localparam logic [3:0] ALU_SLTI = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1110;
    localparam logic [3:0] ALU_JUMP = 4'b1111;

    typedef enum logic [1:0] {
        EXT_SIGN = 2'd0,
        EXT_ZERO = 2'd1,
        EXT_LUI  = 2'd2
    } ext_mode_e;

    // R-type functs the EX ALU implements; anything else traps as illegal
    function automatic logic is_legal_funct(input logic [5:0] funct);
        case (funct)
            6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
            6'b001000, 6'b001001, 6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011:
                is_legal_funct = 1'b1;
            default:
                is_legal_funct = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_issue_alu_ctrl_decode.sv
// rtl/id_ex_issue_alu_ctrl_decode.sv - combinational instruction to ALU control decode
module alu_ctrl_decode
    import id_ex_issue_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  aluop,
    output logic [5:0]  calcode,
    output logic [4:0]  shamt,
    output ext_mode_e   ext_mode,
    output logic        bsel_rt,
    output logic [4:0]  wreg,
    output logic        regwrite,
    output logic        jumplink,
    output logic        illegal
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    always_comb begin
        aluop    = ALU_JUMP;
        calcode  = 6'd0;
        shamt    = 5'd0;
        ext_mode = EXT_SIGN;
        bsel_rt  = 1'b0;
        wreg     = instr[20:16];
        regwrite = 1'b0;
        jumplink = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_RTYPE: begin
                wreg    = instr[15:11];
                bsel_rt = 1'b1;
                if (is_legal_funct(funct)) begin
                    calcode  = funct;
                    shamt    = instr[10:6];
                    regwrite = 1'b1;
                    if (funct == FN_JALR) begin
                        aluop    = ALU_JUMP;
                        jumplink = 1'b1;
                    end else begin
                        aluop = ALU_R;
                    end
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_LW, OP_LB: begin
                aluop    = ALU_MEM;
                regwrite = 1'b1;
            end
            OP_SW, OP_SB: aluop = ALU_MEM;
            OP_LUI: begin
                aluop    = ALU_LUI;
                ext_mode = EXT_LUI;
                regwrite = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                aluop    = ALU_ADDI;
                regwrite = 1'b1;
            end
            OP_ANDI: begin
                aluop    = ALU_ANDI;
                ext_mode = EXT_ZERO;
                regwrite = 1'b1;
            end
            OP_ORI: begin
                aluop    = ALU_ORI;
                ext_mode = EXT_ZERO;
                regwrite = 1'b1;
            end
            OP_XORI: begin
                aluop    = ALU_XORI;
                ext_mode = EXT_ZERO;
                regwrite = 1'b1;
            end
            OP_SLTI: begin
                aluop    = ALU_SLTI;
                regwrite = 1'b1;
            end
            OP_SLTIU: begin
                aluop    = ALU_SLTU;
                regwrite = 1'b1;
            end
            OP_JAL: begin
                wreg     = 5'd31;
                jumplink = 1'b1;
                regwrite = 1'b1;
            end
            OP_BEQ, OP_BNE: bsel_rt = 1'b1;
            OP_J: ;
            default: illegal = 1'b1;
        endcase
        // $0 is hardwired, so a write to it is dropped here rather than in the regfile
        if (wreg == 5'd0) begin
            regwrite = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_issue.sv
// rtl/id_ex_issue.sv - ID/EX register with operand select, stall hold and flush bubble
module id_ex_issue
    import id_ex_issue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] LINK_OFS = 32'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [31:0] ex_A,
    output logic [31:0] ex_B,
    output logic [3:0]  ex_ALUop,
    output logic [5:0]  ex_calCode,
    output logic [4:0]  ex_s,
    output logic [31:0] ex_extImm,
    output logic        ex_ALUjumplink,
    output logic [31:0] ex_PCadd,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_wreg,
    output logic        ex_regwrite,
    output logic        ex_illegal
);

    logic [3:0]  d_aluop;
    logic [5:0]  d_calcode;
    logic [4:0]  d_shamt;
    ext_mode_e   d_ext_mode;
    logic        d_bsel_rt;
    logic [4:0]  d_wreg;
    logic        d_regwrite;
    logic        d_jumplink;
    logic        d_illegal;
    logic [31:0] ext_imm;

    alu_ctrl_decode u_decode (
        .instr    (id_instr),
        .aluop    (d_aluop),
        .calcode  (d_calcode),
        .shamt    (d_shamt),
        .ext_mode (d_ext_mode),
        .bsel_rt  (d_bsel_rt),
        .wreg     (d_wreg),
        .regwrite (d_regwrite),
        .jumplink (d_jumplink),
        .illegal  (d_illegal)
    );

    always_comb begin
        ext_imm = {{16{id_instr[15]}}, id_instr[15:0]};
        case (d_ext_mode)
            EXT_ZERO: ext_imm = {16'd0, id_instr[15:0]};
            EXT_LUI:  ext_imm = {id_instr[15:0], 16'd0};
            default:  ext_imm = {{16{id_instr[15]}}, id_instr[15:0]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && !id_valid)) begin
            ex_valid       <= 1'b0;
            ex_A           <= 32'd0;
            ex_B           <= 32'd0;
            ex_ALUop       <= ALU_JUMP;
            ex_calCode     <= 6'd0;
            ex_s           <= 5'd0;
            ex_extImm      <= 32'd0;
            ex_ALUjumplink <= 1'b0;
            ex_PCadd       <= 32'd0;
            ex_pc          <= RESET_PC;
            ex_wreg        <= 5'd0;
            ex_regwrite    <= 1'b0;
            ex_illegal     <= 1'b0;
        end else if (!stall) begin
            ex_valid       <= 1'b1;
            ex_A           <= id_rs_data;
            ex_B           <= d_bsel_rt ? id_rt_data : ext_imm;
            ex_ALUop       <= d_aluop;
            ex_calCode     <= d_calcode;
            ex_s           <= d_shamt;
            ex_extImm      <= ext_imm;
            ex_ALUjumplink <= d_jumplink;
            ex_PCadd       <= id_pc + LINK_OFS;
            ex_pc          <= id_pc;
            ex_wreg        <= d_wreg;
            ex_regwrite    <= d_regwrite;
            ex_illegal     <= d_illegal;
        end
    end

endmodule

// File: tb/tb_id_ex_issue.sv
// tb/tb_id_ex_issue.sv - directed and randomized checks of id_ex_issue against a decode model
module tb_id_ex_issue;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  aluop;
        logic [5:0]  calcode;
        logic [4:0]  s;
        logic [31:0] extimm;
        logic        jl;
        logic [31:0] pcadd;
        logic [31:0] pc;
        logic [4:0]  wreg;
        logic        rw;
        logic        ill;
    } ex_t;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_A;
    logic [31:0] ex_B;
    logic [3:0]  ex_ALUop;
    logic [5:0]  ex_calCode;
    logic [4:0]  ex_s;
    logic [31:0] ex_extImm;
    logic        ex_ALUjumplink;
    logic [31:0] ex_PCadd;
    logic [31:0] ex_pc;
    logic [4:0]  ex_wreg;
    logic        ex_regwrite;
    logic        ex_illegal;

    int   checks = 0;
    int   passed = 0;
    ex_t  model;
    ex_t  obs;

    id_ex_issue dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_ALUop(ex_ALUop),
        .ex_calCode(ex_calCode), .ex_s(ex_s), .ex_extImm(ex_extImm),
        .ex_ALUjumplink(ex_ALUjumplink), .ex_PCadd(ex_PCadd), .ex_pc(ex_pc),
        .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ex_t bubble();
        ex_t e = '0;
        e.aluop = 4'b1111;
        e.pc    = 32'h3000;
        return e;
    endfunction

    // Reference decode straight from the instruction table
    function automatic ex_t decode(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] rs, input logic [31:0] rt);
        ex_t e = '0;
        logic [5:0]  op    = ins[31:26];
        logic [5:0]  fn    = ins[5:0];
        logic [15:0] imm   = ins[15:0];
        logic [31:0] sx    = {{16{imm[15]}}, imm};
        logic [31:0] zx    = {16'h0, imm};
        logic        use_rt = 1'b0;
        e.valid  = 1'b1;
        e.a      = rs;
        e.pc     = pc;
        e.pcadd  = pc + 32'd8;
        e.extimm = sx;
        e.wreg   = ins[20:16];
        e.aluop  = 4'b1111;
        if (op == 6'd0) begin
            e.wreg = ins[15:11];
            use_rt = 1'b1;
            if (fn inside {0, 2, 3, 4, 6, 7, 8, 9, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43}) begin
                e.calcode = fn;
                e.s       = ins[10:6];
                e.rw      = 1'b1;
                e.aluop   = (fn == 6'd9) ? 4'b1111 : 4'b0000;
                e.jl      = (fn == 6'd9);
            end else begin
                e.ill = 1'b1;
            end
        end else if (op inside {6'h23, 6'h20}) begin e.aluop = 4'd7;  e.rw = 1'b1; end
        else if (op inside {6'h2b, 6'h28})     begin e.aluop = 4'd7; end
        else if (op == 6'h0f) begin e.aluop = 4'd8;  e.extimm = {imm, 16'h0}; e.rw = 1'b1; end
        else if (op inside {6'h08, 6'h09})     begin e.aluop = 4'd9;  e.rw = 1'b1; end
        else if (op == 6'h0c) begin e.aluop = 4'd10; e.extimm = zx; e.rw = 1'b1; end
        else if (op == 6'h0d) begin e.aluop = 4'd11; e.extimm = zx; e.rw = 1'b1; end
        else if (op == 6'h0e) begin e.aluop = 4'd12; e.extimm = zx; e.rw = 1'b1; end
        else if (op == 6'h0a) begin e.aluop = 4'd13; e.rw = 1'b1; end
        else if (op == 6'h0b) begin e.aluop = 4'd14; e.rw = 1'b1; end
        else if (op == 6'h03) begin e.wreg = 5'd31; e.jl = 1'b1; e.rw = 1'b1; end
        else if (op inside {6'h04, 6'h05}) use_rt = 1'b1;
        else if (op == 6'h02) ;
        else e.ill = 1'b1;
        if (e.wreg == 5'd0) e.rw = 1'b0;
        e.b = use_rt ? rt : e.extimm;
        return e;
    endfunction

    function automatic ex_t observe();
        return {ex_valid, ex_A, ex_B, ex_ALUop, ex_calCode, ex_s, ex_extImm, ex_ALUjumplink,
                ex_PCadd, ex_pc, ex_wreg, ex_regwrite, ex_illegal};
    endfunction

    // Drive one cycle of inputs, advance the model by the reset > flush > stall > load rule
    task automatic cycle(input logic rst, input logic fl, input logic st, input logic v,
                         input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] rs, input logic [31:0] rt);
        reset = rst; flush = fl; stall = st; id_valid = v;
        id_instr = ins; id_pc = pc; id_rs_data = rs; id_rt_data = rt;
        if (rst || fl)      model = bubble();
        else if (st)        model = model;
        else if (!v)        model = bubble();
        else                model = decode(ins, pc, rs, rt);
        @(posedge clk);
        #1;
        obs = observe();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 0, 1, 32'h00221821, 32'h100, 32'd1, 32'd2);
            checks++;
            if (ex_valid !== 1'b0 || ex_pc !== 32'h3000 || ex_ALUop !== 4'b1111 || ex_regwrite !== 1'b0)
                $display("FAIL reset_fields: got valid=%b pc=%h op=%b rw=%b want 0/3000/1111/0",
                         ex_valid, ex_pc, ex_ALUop, ex_regwrite);
            else passed++;
            checks++;
            if (obs !== model) $display("FAIL reset_all: got %h want %h", obs, model);
            else passed++;
        end
    endtask

    task automatic test_addu();
        cycle(0, 0, 0, 1, 32'h00221821, 32'h3004, 32'd5, 32'd7);
        checks++;
        if (ex_ALUop !== 4'b0000 || ex_calCode !== 6'b100001 || ex_A !== 32'd5 || ex_B !== 32'd7 ||
            ex_wreg !== 5'd3 || ex_regwrite !== 1'b1 || ex_valid !== 1'b1)
            $display("FAIL addu: got op=%b cc=%b A=%h B=%h wreg=%0d rw=%b", ex_ALUop, ex_calCode,
                     ex_A, ex_B, ex_wreg, ex_regwrite);
        else passed++;
    endtask

    task automatic test_imm();
        cycle(0, 0, 0, 1, 32'h3404FFFF, 32'h3008, 32'd0, 32'h55);
        checks++;
        if (ex_extImm !== 32'h0000FFFF || ex_B !== 32'h0000FFFF || ex_ALUop !== 4'b1011)
            $display("FAIL ori: got ext=%h B=%h op=%b want 0000ffff/0000ffff/1011",
                     ex_extImm, ex_B, ex_ALUop);
        else passed++;
        cycle(0, 0, 0, 1, 32'h2004FFFF, 32'h300C, 32'd0, 32'h55);
        checks++;
        if (ex_extImm !== 32'hFFFFFFFF || ex_ALUop !== 4'b1001 || ex_ALUjumplink !== 1'b0)
            $display("FAIL addi: got ext=%h op=%b jl=%b want ffffffff/1001/0",
                     ex_extImm, ex_ALUop, ex_ALUjumplink);
        else passed++;
    endtask

    task automatic test_jal();
        cycle(0, 0, 0, 1, 32'h0C000C04, 32'h3010, 32'd1, 32'd2);
        checks++;
        if (ex_ALUop !== 4'b1111 || ex_ALUjumplink !== 1'b1 || ex_PCadd !== 32'h3018 ||
            ex_wreg !== 5'd31 || ex_regwrite !== 1'b1)
            $display("FAIL jal: got op=%b jl=%b pcadd=%h wreg=%0d rw=%b",
                     ex_ALUop, ex_ALUjumplink, ex_PCadd, ex_wreg, ex_regwrite);
        else passed++;
        cycle(0, 0, 0, 1, 32'h0C000000, 32'hFFFFFFFC, 32'd1, 32'd2);
        checks++;
        if (ex_PCadd !== 32'h4) $display("FAIL jal_wrap: got pcadd=%h want 00000004", ex_PCadd);
        else passed++;
    endtask

    task automatic test_stall_flush();
        ex_t held;
        cycle(0, 0, 0, 1, 32'h00221821, 32'h3020, 32'd11, 32'd22);
        held = obs;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 1, $urandom, $urandom, $urandom, $urandom);
            checks++;
            if (obs !== held || obs !== model) $display("FAIL stall_hold: got %h want %h", obs, held);
            else passed++;
        end
        cycle(0, 1, 1, 1, 32'h00221821, 32'h3024, 32'd1, 32'd2);
        checks++;
        if (obs !== bubble()) $display("FAIL stall_flush: got %h want %h", obs, bubble());
        else passed++;
        cycle(0, 0, 0, 0, 32'h00221821, 32'h3028, 32'd1, 32'd2);
        checks++;
        if (obs !== bubble()) $display("FAIL invalid_load: got %h want %h", obs, bubble());
        else passed++;
    endtask

    task automatic test_illegal();
        cycle(0, 0, 0, 1, 32'hFC0A0000, 32'h3030, 32'd3, 32'd4);
        checks++;
        if (ex_illegal !== 1'b1 || ex_regwrite !== 1'b0 || ex_valid !== 1'b1 ||
            ex_ALUop !== 4'b1111 || ex_ALUjumplink !== 1'b0)
            $display("FAIL illegal_op: got ill=%b rw=%b valid=%b op=%b jl=%b",
                     ex_illegal, ex_regwrite, ex_valid, ex_ALUop, ex_ALUjumplink);
        else passed++;
        cycle(0, 0, 0, 1, 32'h3C001234, 32'h3034, 32'd3, 32'd4);
        checks++;
        if (ex_regwrite !== 1'b0 || ex_extImm !== 32'h12340000 || ex_ALUop !== 4'b1000)
            $display("FAIL lui_r0: got rw=%b ext=%h op=%b want 0/12340000/1000",
                     ex_regwrite, ex_extImm, ex_ALUop);
        else passed++;
    endtask

    task automatic test_random();
        logic [5:0]  ops [17] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b,
                                  6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h23, 6'h28, 6'h2b};
        logic [31:0] ins;
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[31:26] = ops[$urandom_range(0, 16)];
            if (ins[31:26] == 6'h00 && $urandom_range(0, 2) != 0)
                ins[5:0] = ($urandom_range(0, 1) == 0) ? 6'd9 : 6'h21;
            if ($urandom_range(0, 7) == 0) ins[15:11] = 5'd0;
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0,
                  ins, $urandom, $urandom, $urandom);
            checks++;
            if (obs !== model) $display("FAIL random_%0d: instr=%h got %h want %h", i, ins, obs, model);
            else passed++;
        end
    endtask

    initial begin
        model = bubble();
        reset = 1'b1; flush = 1'b0; stall = 1'b0; id_valid = 1'b0;
        id_instr = '0; id_pc = '0; id_rs_data = '0; id_rt_data = '0;
        test_reset();
        test_addu();
        test_imm();
        test_jal();
        test_stall_flush();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
